multiphase_clock_gen: RTL and testbench



---
 rtl/multiphase_clock_gen_pkg.sv | 19 +
 rtl/multiphase_clock_gen_if.sv | 25 ++
 rtl/multiphase_clock_gen_slot_timer.sv | 27 ++
 rtl/multiphase_clock_gen.sv | 127 ++++++++++++
 tb/tb_multiphase_clock_gen.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/multiphase_clock_gen_pkg.sv
// Shared types and helpers for the multiphase clock generator.
// Optional single-step start is enabled with macro CLKGEN_STEP_EN.
package clkgen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    ACTIVE = 2'd2
  } clkgen_state_e;

  localparam int MAX_PHASES = 8;
  localparam int IDX_W      = $clog2(MAX_PHASES);

  // Zero-length slots are stretched to one cycle so every window is real.
  function automatic logic [31:0] sat1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/multiphase_clock_gen_if.sv
// Control and phase-output bundle of the multiphase clock generator.
interface multiphase_clock_gen_if #(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 4
);
  logic                  RUN;
  logic [CNT_W-1:0]      PH_WIDTH;
  logic [CNT_W-1:0]      GAP_WIDTH;
  logic                  STEP;
  logic [NUM_PHASES-1:0] PH;
  logic                  DEBUG;
  logic                  O_S;
  logic                  CYC_END;
  logic                  BUSY;

  modport master (
    output RUN, PH_WIDTH, GAP_WIDTH, STEP,
    input  PH, DEBUG, O_S, CYC_END, BUSY
  );

  modport slave (
    input  RUN, PH_WIDTH, GAP_WIDTH, STEP,
    output PH, DEBUG, O_S, CYC_END, BUSY
  );
endinterface

// File: rtl/multiphase_clock_gen_slot_timer.sv
// Loadable down-counter timing one gap or active slot.
module clkgen_slot_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on slot entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (cnt_q != '0)        cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/multiphase_clock_gen.sv
// Multiphase non-overlapping clock generator: NUM_PHASES one-hot phase
// enables separated by programmable gaps. Macro CLKGEN_STEP_EN adds a
// single-major-cycle start from IDLE via STEP.
module multiphase_clock_gen
  import clkgen_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int CNT_W      = 4,
  parameter int DEF_RUN    = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  multiphase_clock_gen_if.slave  bus
);
  if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES || DEF_RUN != 1) begin : g_bad_cfg
    $error("multiphase_clock_gen: unsupported parameter set");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  clkgen_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      g_q, g_d, w_q, w_d;
  logic [NUM_PHASES-1:0] ph_q, ph_d;
  logic                  dbg_q, dbg_d, os_q, os_d, ce_q, ce_d;
  logic                  load, done, start;
  logic [CNT_W-1:0]      load_val, g_in, w_in;

  assign g_in = CNT_W'(sat1(32'(bus.GAP_WIDTH)));
  assign w_in = CNT_W'(sat1(32'(bus.PH_WIDTH)));

`ifdef CLKGEN_STEP_EN
  // Only consulted in IDLE, so STEP while busy has no effect.
  assign start = bus.RUN | bus.STEP;
`else
  assign start = bus.RUN;
`endif

  clkgen_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Next state, slot loads and registered output values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    g_d      = g_q;
    w_d      = w_q;
    os_d     = os_q;
    ce_d     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = GAP;
        idx_d    = '0;
        g_d      = g_in;
        w_d      = w_in;
        load     = 1'b1;
        load_val = g_in - 1'b1;
      end
      GAP: if (done) begin
        state_d  = ACTIVE;
        load     = 1'b1;
        load_val = w_q - 1'b1;
        os_d     = ~os_q;
      end
      ACTIVE: if (done) begin
        if (idx_q != LAST_IDX) begin
          state_d  = GAP;
          idx_d    = idx_q + 1'b1;
          load     = 1'b1;
          load_val = g_q - 1'b1;
        end else begin
          ce_d  = 1'b1;
          idx_d = '0;
          if (bus.RUN) begin
            // Major-cycle boundary: pick up new widths here only.
            state_d  = GAP;
            g_d      = g_in;
            w_d      = w_in;
            load     = 1'b1;
            load_val = g_in - 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ph_d  = (state_d == ACTIVE) ? (NUM_PHASES'(1) << idx_d) : '0;
    dbg_d = (state_d == GAP);
  end

  // State and output registers; reset drops PH at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      g_q     <= CNT_W'(1);
      w_q     <= CNT_W'(1);
      ph_q    <= '0;
      dbg_q   <= 1'b0;
      os_q    <= 1'b1;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      g_q     <= g_d;
      w_q     <= w_d;
      ph_q    <= ph_d;
      dbg_q   <= dbg_d;
      os_q    <= os_d;
      ce_q    <= ce_d;
    end
  end

  assign bus.PH      = ph_q;
  assign bus.DEBUG   = dbg_q;
  assign bus.O_S     = os_q;
  assign bus.CYC_END = ce_q;
  assign bus.BUSY    = (state_q != IDLE);
endmodule

// File: tb/tb_multiphase_clock_gen.sv
// Directed bench for multiphase_clock_gen: a 2-phase and a 3-phase instance.
module tb_multiphase_clock_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multiphase_clock_gen_if #(.NUM_PHASES(2), .CNT_W(4)) b2 ();
  multiphase_clock_gen_if #(.NUM_PHASES(3), .CNT_W(4)) b3 ();

  multiphase_clock_gen #(.NUM_PHASES(2), .CNT_W(4), .DEF_RUN(1)) dut2 (
    .CLK(clk), .RST_N(rst_n), .bus(b2));
  multiphase_clock_gen #(.NUM_PHASES(3), .CNT_W(4), .DEF_RUN(1)) dut3 (
    .CLK(clk), .RST_N(rst_n), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected phase pattern at position pos (0 = first gap cycle of a major cycle).
  function automatic logic [31:0] exp_ph(input int pos, input int g, input int w, input int n);
    int slot, off;
    slot = (pos / (g + w)) % n;
    off  = pos % (g + w);
    return (off < g) ? 32'd0 : (32'd1 << slot);
  endfunction

  logic [7:0] t1_ph  [8] = '{0, 1, 0, 2, 0, 1, 0, 2};
  logic       t1_dbg [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  logic       t1_os  [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
  logic       t1_ce  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
    int hi [3];
    int ce_cnt;
    rst_n = 1'b0;
    b2.RUN = 1'b1; b2.GAP_WIDTH = 4'd1; b2.PH_WIDTH = 4'd1; b2.STEP = 1'b0;
    b3.RUN = 1'b0; b3.GAP_WIDTH = 4'd2; b3.PH_WIDTH = 4'd3; b3.STEP = 1'b0;
    repeat (2) tick();
    chk("rst_ph",   32'(b2.PH), 0);
    chk("rst_dbg",  32'(b2.DEBUG), 0);
    chk("rst_os",   32'(b2.O_S), 1);
    chk("rst_ce",   32'(b2.CYC_END), 0);
    chk("rst_busy", 32'(b2.BUSY), 0);
    rst_n = 1'b1;

    // 1: N=2, 1/1 free-running
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("t1_ph_c%0d", c + 1),  32'(b2.PH), 32'(t1_ph[c]));
      chk($sformatf("t1_dbg_c%0d", c + 1), 32'(b2.DEBUG), 32'(t1_dbg[c]));
      chk($sformatf("t1_os_c%0d", c + 1),  32'(b2.O_S), 32'(t1_os[c]));
      chk($sformatf("t1_ce_c%0d", c + 1),  32'(b2.CYC_END), 32'(t1_ce[c]));
      chk($sformatf("t1_busy_c%0d", c + 1), 32'(b2.BUSY), 1);
    end

    // 4: drop RUN inside the PH[0] window, cycle still completes
    tick(); chk("t4_c9_ce", 32'(b2.CYC_END), 1);
    tick(); chk("t4_c10_ph", 32'(b2.PH), 1); chk("t4_c10_os", 32'(b2.O_S), 0);
    b2.RUN = 1'b0;
    tick(); chk("t4_c11_ph", 32'(b2.PH), 0); chk("t4_c11_dbg", 32'(b2.DEBUG), 1);
    tick(); chk("t4_c12_ph", 32'(b2.PH), 2); chk("t4_c12_os", 32'(b2.O_S), 1);
    tick(); chk("t4_c13_ce", 32'(b2.CYC_END), 1); chk("t4_c13_busy", 32'(b2.BUSY), 0);
    chk("t4_c13_ph", 32'(b2.PH), 0); chk("t4_c13_dbg", 32'(b2.DEBUG), 0);
    tick(); chk("t4_c14_ce", 32'(b2.CYC_END), 0); chk("t4_c14_busy", 32'(b2.BUSY), 0);
    chk("t4_c14_os", 32'(b2.O_S), 1);

    // 2: N=3, gap 2, width 3, period 15
    hi = '{0, 0, 0};
    b3.RUN = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      chk($sformatf("t2_ph_c%0d", c + 1), 32'(b3.PH), exp_ph(c, 2, 3, 3));
      chk($sformatf("t2_1hot_c%0d", c + 1), 32'($onehot0(b3.PH)), 1);
      chk($sformatf("t2_ce_c%0d", c + 1), 32'(b3.CYC_END), 0);
      for (int b = 0; b < 3; b++) if (b3.PH[b]) hi[b]++;
    end
    for (int b = 0; b < 3; b++) chk($sformatf("t2_hi%0d", b), 32'(hi[b]), 3);
    b3.RUN = 1'b0;
    tick(); chk("t2_c16_ce", 32'(b3.CYC_END), 1); chk("t2_c16_busy", 32'(b3.BUSY), 0);

    // 3: zero widths act as 1/1; PH_WIDTH=5 lands at the next major cycle
    b2.GAP_WIDTH = 4'd0; b2.PH_WIDTH = 4'd0; b2.RUN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t3a_ph_c%0d", c + 1), 32'(b2.PH), exp_ph(c, 1, 1, 2));
      if (c == 1) b2.PH_WIDTH = 4'd5;
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("t3b_ph_c%0d", c + 5), 32'(b2.PH), exp_ph(c, 1, 5, 2));
      if (c == 0) chk("t3b_ce_c5", 32'(b2.CYC_END), 1);
      if (c == 5) b2.RUN = 1'b0;
    end
    tick(); chk("t3_c17_ce", 32'(b2.CYC_END), 1); chk("t3_c17_busy", 32'(b2.BUSY), 0);

    // 5: async reset mid PH[1] window, restart begins with a gap
    b2.GAP_WIDTH = 4'd2; b2.PH_WIDTH = 4'd3; b2.RUN = 1'b1;
    repeat (9) tick();
    chk("t5_pre_ph", 32'(b2.PH), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ph", 32'(b2.PH), 0);
    chk("t5_rst_dbg", 32'(b2.DEBUG), 0);
    chk("t5_rst_os", 32'(b2.O_S), 1);
    tick(); rst_n = 1'b1;
    tick(); chk("t5_r1_dbg", 32'(b2.DEBUG), 1); chk("t5_r1_ph", 32'(b2.PH), 0);
    tick(); chk("t5_r2_ph", 32'(b2.PH), 0);
    tick(); chk("t5_r3_ph", 32'(b2.PH), 1); chk("t5_r3_os", 32'(b2.O_S), 0);
    b2.RUN = 1'b0;
    for (int i = 0; i < 20 && b2.BUSY; i++) tick();
    chk("t5_idle_timeout", 32'(b2.BUSY), 0);

    // 6: single step, or STEP ignored in the default build
    b2.GAP_WIDTH = 4'd1; b2.PH_WIDTH = 4'd1;
    tick();
    b2.STEP = 1'b1;
    tick(); b2.STEP = 1'b0;
`ifdef CLKGEN_STEP_EN
    ce_cnt = 0;
    chk("t6_r1_dbg", 32'(b2.DEBUG), 1);
    tick(); chk("t6_r2_ph", 32'(b2.PH), 1);
    b2.STEP = 1'b1;
    tick(); b2.STEP = 1'b0; chk("t6_r3_ph", 32'(b2.PH), 0);
    tick(); chk("t6_r4_ph", 32'(b2.PH), 2);
    tick(); chk("t6_r5_ce", 32'(b2.CYC_END), 1); chk("t6_r5_busy", 32'(b2.BUSY), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b2.CYC_END) ce_cnt++;
      chk($sformatf("t6_idle_%0d", i), 32'(b2.BUSY), 0);
    end
    chk("t6_extra_ce", 32'(ce_cnt), 0);
`else
    ce_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t6_busy_%0d", i), 32'(b2.BUSY), 0);
      chk($sformatf("t6_ph_%0d", i), 32'(b2.PH), 0);
      if (b2.CYC_END) ce_cnt++;
      tick();
    end
    chk("t6_ce_none", 32'(ce_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
